sync_edge_det_multi: RTL
========================

Name: sync_edge_det_multi

Overview:
- Multi-channel synchroniser and edge detector in a single clock domain (clkb).
- Takes CH asynchronous level or toggle inputs from foreign domains. Each channel passes through a SYNC_STAGES-deep flop chain, an optional glitch filter and a per-channel edge-mode selector, and produces a one-cycle pulse.
- Per-channel sticky flags, saturating event counters and overflow flags support software/status readout.
- Generalised successor of the single-channel toggle-to-pulse synchroniser: parametrised channel count, stage count, filtering, selectable edge mode, event accounting.

Parameters:
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_LEN, 0, consecutive cycles a changed synchronised level must persist before acceptance; 0 and 1 both mean no filtering
- CNT_W, 8, width of each per-channel event counter (≥1)

Ports:
- clkb  input  1  destination clock, all logic rising-edge
- rstnb  input  1  asynchronous active-low reset
- din  input  CH  asynchronous per-channel inputs, no timing relation to clkb
- mode  input  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both edges (toggle mode)
- clr  input  CH  synchronous per-channel clear of sticky, cnt, ovf
- level  output  CH  synchronised, filtered level per channel
- pulse  output  CH  one-cycle event strobe per channel
- sticky  output  CH  set by pulse, held until clr
- cnt  output  CH*CNT_W  per-channel saturating event count, channel i at [i*CNT_W +: CNT_W]
- ovf  output  CH  set when an event arrives while cnt is saturated

Behaviour:
- Reset (rstnb low, asynchronous): every sync flop, filter counter, level, pulse, sticky, cnt and ovf go to 0 immediately; all held at 0 while rstnb is low.
- Sync chain: s[0] <= din; s[k] <= s[k-1]. Only s[SYNC_STAGES-1] is used downstream; no other logic may read din or intermediate stages.
- Edge numbering: edge 1 is the first clkb edge at which s[0] captures a new din value.
- Filter, FILTER_LEN ≤ 1: level <= s[last] every edge, so level changes at edge SYNC_STAGES+1.
- Filter, FILTER_LEN = F ≥ 2:
  - Per-channel counter, width clog2(F)+1, increments each edge while s[last] != level and resets to 0 on any edge where they match.
  - When the counter would reach F, level flips and the counter clears, so level changes at edge SYNC_STAGES+F.
  - Any s[last] excursion shorter than F cycles produces no level change and no pulse.
- Event detection: evt_i is computed from the level transition taken on an edge, qualified by mode. 01 requires 0→1, 10 requires 1→0, 11 accepts either, 00 produces none.
  - pulse_i is registered high in the same edge that level_i flips and is low on the next edge unless another qualifying flip occurs.
  - Total latency from edge 1 is SYNC_STAGES + max(FILTER_LEN,1) edges.
- Mode: sampled every cycle. A mode change never creates a pulse by itself. level tracks din regardless of mode.
- Toggle mode (11): each din toggle from the source domain yields exactly one pulse, provided toggles are spaced ≥ SYNC_STAGES+max(FILTER_LEN,1)+1 clkb cycles. Closer spacing may merge events; this is a source-side constraint, not detected.
- Counter: cnt_i increments by 1 on pulse_i and saturates at 2^CNT_W-1. A pulse while saturated sets ovf_i; cnt_i is held.
- sticky_i: set on pulse_i, cleared only by clr_i or reset.
- clr_i without pulse_i, on that edge: sticky_i=0, cnt_i=0, ovf_i=0.
- clr_i with pulse_i on the same edge: the event is not lost; result is cnt_i=1, sticky_i=1, ovf_i=0.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset release with din_i held 1: level_i rises after the normal latency and generates a rising/both event if enabled. This is intentional and not masked.

Test Plan:
- Rising edge, no filter: CH=4, SYNC_STAGES=2, FILTER_LEN=0, mode0=01; din[0] 0→1 -> level[0] and pulse[0] high at edge 3, pulse[0] low at edge 4, cnt0=1, sticky[0]=1; din[0] 1→0 -> no pulse.
- Toggle mode: mode1=11; din[1] toggled 5 times, 8 cycles apart -> exactly 5 one-cycle pulses, cnt1=5.
- Glitch filter: FILTER_LEN=4; din[2] high for 3 cycles -> no level change, no pulse. Then high for 6 cycles -> level[2] rises at edge SYNC_STAGES+4, one pulse.
- Saturation and clear: CNT_W=2, mode3=11; 5 events -> cnt3 saturates at 3 after event 3, ovf[3]=1 on event 4 and stays 1. clr[3] alone -> cnt3=0, ovf[3]=0, sticky[3]=0. clr[3] coincident with a pulse -> cnt3=1, sticky[3]=1.
- Mode off and mode switch: mode0=00, din[0] toggles -> level follows, no pulse, cnt0 unchanged. Switch mode0 00→11 with level stable -> no pulse.
- Reset mid-operation: assert rstnb low with a pulse in flight and cnt≠0 -> all outputs 0 asynchronously. Release with din[0]=1, mode0=01 -> single rising pulse after 3 edges.

Source files
------------

// File: rtl/sync_edge_det_multi.sv
// Multi-channel synchroniser with optional glitch filter, per-channel edge-mode
// selection, one-cycle event pulses, sticky flags and saturating event counters.
module sync_edge_det_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0,
    parameter int CNT_W       = 8
) (
    input  logic                  clkb,
    input  logic                  rstnb,
    input  logic [CH-1:0]         din,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         pulse,
    output logic [CH-1:0]         sticky,
    output logic [CH*CNT_W-1:0]   cnt,
    output logic [CH-1:0]         ovf
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic edge_qual(input logic [1:0] m, input logic prev, input logic nxt);
        logic q;
        case (m)
            2'b01:   q = nxt & ~prev;
            2'b10:   q = ~nxt & prev;
            2'b11:   q = nxt ^ prev;
            default: q = 1'b0;
        endcase
        return q;
    endfunction

    genvar i;
    for (i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_p0;
        logic                   s_last;
        logic                   level_nxt;
        logic                   evt;
        logic                   level_p1;
        logic                   pulse_p1;
        logic                   sticky_p1;
        logic [CNT_W-1:0]       cnt_p1;
        logic                   ovf_p1;

        assign s_last = sync_p0[SYNC_STAGES-1];

        // Filter stage: level only follows the synchronised input after it
        // has disagreed with level for FILTER_LEN consecutive edges.
        if (FILTER_LEN >= 2) begin : g_filt
            localparam int FW = $clog2(FILTER_LEN) + 1;
            localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
            logic [FW-1:0] fcnt_p1;

            always_ff @(posedge clkb or negedge rstnb) begin
                if (!rstnb) begin
                    fcnt_p1 <= '0;
                end else if (s_last != level_p1) begin
                    fcnt_p1 <= (fcnt_p1 == F_LAST) ? '0 : fcnt_p1 + FW'(1);
                end else begin
                    fcnt_p1 <= '0;
                end
            end

            assign level_nxt = ((s_last != level_p1) && (fcnt_p1 == F_LAST)) ? ~level_p1 : level_p1;
        end else begin : g_nofilt
            assign level_nxt = s_last;
        end

        assign evt = edge_qual(mode[2*i +: 2], level_p1, level_nxt);

        // Output stage: level, pulse and accounting all update on the flip edge.
        always_ff @(posedge clkb or negedge rstnb) begin
            if (!rstnb) begin
                sync_p0   <= '0;
                level_p1  <= 1'b0;
                pulse_p1  <= 1'b0;
                sticky_p1 <= 1'b0;
                cnt_p1    <= '0;
                ovf_p1    <= 1'b0;
            end else begin
                sync_p0  <= {sync_p0[SYNC_STAGES-2:0], din[i]};
                level_p1 <= level_nxt;
                pulse_p1 <= evt;
                if (clr[i]) begin
                    // A coinciding event survives the clear as the first count.
                    sticky_p1 <= evt;
                    cnt_p1    <= evt ? CNT_W'(1) : '0;
                    ovf_p1    <= 1'b0;
                end else if (evt) begin
                    sticky_p1 <= 1'b1;
                    cnt_p1    <= sat_inc(cnt_p1);
                    if (&cnt_p1) begin
                        ovf_p1 <= 1'b1;
                    end
                end
            end
        end

        assign level[i]                = level_p1;
        assign pulse[i]                = pulse_p1;
        assign sticky[i]               = sticky_p1;
        assign cnt[i*CNT_W +: CNT_W]   = cnt_p1;
        assign ovf[i]                  = ovf_p1;
    end

endmodule
